ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/muldiv_unit.sv | 104 ++++++++++
 rtl/ex_stage.sv | 92 +++++++++
 tb/tb_ex_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the EX stage: ALU operation codes, mul/div FSM states,
// iteration count and the operand forwarding mux.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_MUL  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REMU = 4'd14,
        ALU_ZERO = 4'd15
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int MULDIV_STEPS = 32;

    // MEM beats WB; register $0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] reg_val,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_val,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_val
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return mem_val;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return wb_val;
        else
            return reg_val;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiplier / restoring divider for the EX stage.
// state | meaning
// IDLE  | waiting; a mul/div code latches operands and starts the run
// RUN   | one shift-add or restore step per cycle, 32 steps
// DONE  | result register valid for one cycle, EX released
module muldiv_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] result
);

    md_state_e   state, state_nx;
    alu_ctrl_e   op, op_q;
    logic [4:0]  count;
    logic [31:0] acc, x, y;
    logic [31:0] acc_nx, x_nx, y_nx;
    logic [31:0] result_q;
    logic [32:0] r_shift;
    logic [31:0] trial;
    logic        fits, is_md, start, step, last;

    assign op     = alu_ctrl_e'(ctrl);
    assign is_md  = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    assign last   = (count == 5'(MULDIV_STEPS - 1));
    assign result = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        if (kill) begin
            state_nx = MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: if (is_md) begin
                    busy     = 1'b1;
                    start    = 1'b1;
                    state_nx = MD_RUN;
                end
                MD_RUN: begin
                    busy = 1'b1;
                    step = 1'b1;
                    if (last) state_nx = MD_DONE;
                end
                MD_DONE: state_nx = MD_IDLE;
                default: state_nx = MD_IDLE;
            endcase
        end
    end

    // acc holds the partial product or running remainder; x the multiplicand
    // or the dividend shifting out / quotient shifting in; y multiplier or divisor.
    always_comb begin
        r_shift = {acc, x[31]};
        fits    = (r_shift >= {1'b0, y});
        trial   = r_shift[31:0] - y;
        if (op_q == ALU_MUL) begin
            acc_nx = y[0] ? (acc + x) : acc;
            x_nx   = x << 1;
            y_nx   = y >> 1;
        end else begin
            acc_nx = fits ? trial : r_shift[31:0];
            x_nx   = {x[30:0], fits};
            y_nx   = y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            op_q     <= ALU_ADD;
            acc      <= '0;
            x        <= '0;
            y        <= '0;
            result_q <= '0;
        end else if (start) begin
            count <= '0;
            op_q  <= op;
            acc   <= '0;
            x     <= a;
            y     <= b;
        end else if (step) begin
            count <= count + 5'd1;
            acc   <= acc_nx;
            x     <= x_nx;
            y     <= y_nx;
            if (last) result_q <= (op_q == ALU_DIVU) ? x_nx : acc_nx;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Pipeline EX stage: forwarding, ALU, branch resolution and optional
// iterative mul/div (enabled by EX_MULDIV_EN).
module ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_rs1_val,
    input  logic [31:0] ex_rs2_val,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_pc_plus4,
    input  logic [4:0]  ex_shamt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic [3:0]  ex_alu_ctrl,
    input  logic        ex_alu_src,
    input  logic        ex_reg_dst,
    input  logic        ex_is_branch,
    input  logic        ex_is_branch_ne,
    input  logic        ex_jal,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    input  logic        ex_kill,
    output logic [31:0] alu_result,
    output logic [31:0] store_val,
    output logic [31:0] branch_target,
    output logic [4:0]  dest_reg,
    output logic        branch_taken,
    output logic        ex_busy
);

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_val, md_result;

    assign fwd_a = fwd_sel(ex_rs, ex_rs1_val, mem_reg_write, mem_rd, mem_fwd_val,
                           wb_reg_write, wb_rd, wb_fwd_val);
    assign fwd_b = fwd_sel(ex_rt, ex_rs2_val, mem_reg_write, mem_rd, mem_fwd_val,
                           wb_reg_write, wb_rd, wb_fwd_val);
    assign op_a      = fwd_a;
    assign op_b      = ex_alu_src ? ex_imm : fwd_b;
    assign store_val = fwd_b;

`ifdef EX_MULDIV_EN
    muldiv_unit u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .kill   (ex_kill),
        .ctrl   (ex_alu_ctrl),
        .a      (op_a),
        .b      (op_b),
        .busy   (ex_busy),
        .result (md_result)
    );
`else
    logic unused_md;
    assign unused_md = &{1'b0, clk, reset, ex_kill};
    assign ex_busy   = 1'b0;
    assign md_result = '0;
`endif

    always_comb begin
        alu_val = '0;
        case (alu_ctrl_e'(ex_alu_ctrl))
            ALU_ADD:  alu_val = op_a + op_b;
            ALU_SUB:  alu_val = op_a - op_b;
            ALU_AND:  alu_val = op_a & op_b;
            ALU_OR:   alu_val = op_a | op_b;
            ALU_XOR:  alu_val = op_a ^ op_b;
            ALU_NOR:  alu_val = ~(op_a | op_b);
            ALU_SLT:  alu_val = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_val = {31'd0, op_a < op_b};
            ALU_SLL:  alu_val = op_b << ex_shamt;
            ALU_SRL:  alu_val = op_b >> ex_shamt;
            ALU_SRA:  alu_val = 32'($signed(op_b) >>> ex_shamt);
            ALU_LUI:  alu_val = {ex_imm[15:0], 16'd0};
            ALU_MUL, ALU_DIVU, ALU_REMU: alu_val = md_result;
            ALU_ZERO: alu_val = '0;
            default:  alu_val = '0;
        endcase
    end

    assign alu_result    = ex_jal ? ex_pc_plus4 : alu_val;
    assign dest_reg      = ex_jal ? 5'd31 : (ex_reg_dst ? ex_rd : ex_rt);
    assign branch_target = ex_pc_plus4 + (ex_imm << 2);
    assign branch_taken  = (ex_is_branch && (op_a == fwd_b)) ||
                           (ex_is_branch_ne && (op_a != fwd_b));

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; mul/div timing vectors apply
// when EX_MULDIV_EN is defined, otherwise the disabled behaviour is checked.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc_plus4;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src, ex_reg_dst, ex_is_branch, ex_is_branch_ne, ex_jal;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        ex_kill;
    logic [31:0] alu_result, store_val, branch_target;
    logic [4:0]  dest_reg;
    logic        branch_taken, ex_busy;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ex_rs1_val      (ex_rs1_val),
        .ex_rs2_val      (ex_rs2_val),
        .ex_imm          (ex_imm),
        .ex_pc_plus4     (ex_pc_plus4),
        .ex_shamt        (ex_shamt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_alu_src      (ex_alu_src),
        .ex_reg_dst      (ex_reg_dst),
        .ex_is_branch    (ex_is_branch),
        .ex_is_branch_ne (ex_is_branch_ne),
        .ex_jal          (ex_jal),
        .mem_reg_write   (mem_reg_write),
        .wb_reg_write    (wb_reg_write),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_fwd_val     (mem_fwd_val),
        .wb_fwd_val      (wb_fwd_val),
        .ex_kill         (ex_kill),
        .alu_result      (alu_result),
        .store_val       (store_val),
        .branch_target   (branch_target),
        .dest_reg        (dest_reg),
        .branch_taken    (branch_taken),
        .ex_busy         (ex_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_rs1_val = '0; ex_rs2_val = '0; ex_imm = '0; ex_pc_plus4 = '0;
        ex_shamt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_alu_ctrl = '0; ex_alu_src = 1'b0; ex_reg_dst = 1'b0;
        ex_is_branch = 1'b0; ex_is_branch_ne = 1'b0; ex_jal = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; mem_rd = '0; wb_rd = '0;
        mem_fwd_val = '0; wb_fwd_val = '0; ex_kill = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] shamt,
                           input logic [31:0] imm, input logic [31:0] exp);
        ex_alu_ctrl = ctrl; ex_rs1_val = a; ex_rs2_val = b;
        ex_shamt = shamt; ex_imm = imm; ex_alu_src = 1'b0;
        #1;
        chk(tag, alu_result, exp);
        chk({tag, "_busy"}, {31'd0, ex_busy}, 32'd0);
    endtask

    // Counts cycles with ex_busy high, starting from the current cycle.
    task automatic count_busy(output int n);
        n = 0;
        while (ex_busy && n < 100) begin
            n++;
            cycle();
        end
    endtask

    initial begin
        int n;
        clear_inputs();
        reset = 1'b1;
        ex_rs1_val = 32'd5; ex_rs2_val = 32'd7; ex_alu_ctrl = 4'd1;
        #2;
        chk("reset_busy", {31'd0, ex_busy}, 32'd0);
        chk("reset_comb_sub", alu_result, 32'hFFFF_FFFE);
        cycle();
        cycle();
        reset = 1'b0;
        #1;

        alu_vec("sub",  4'd1,  32'd5,          32'd7,          5'd0,  32'd0,      32'hFFFF_FFFE);
        alu_vec("add",  4'd0,  32'd5,          32'd7,          5'd0,  32'd0,      32'd12);
        alu_vec("addw", 4'd0,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,      32'd0);
        alu_vec("and",  4'd2,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'd0,      32'h00F0_000F);
        alu_vec("or",   4'd3,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'd0,      32'hFFF0_0FFF);
        alu_vec("xor",  4'd4,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'd0,      32'hFF00_0FF0);
        alu_vec("nor",  4'd5,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'd0,      32'h000F_F000);
        alu_vec("slt",  4'd6,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,      32'd1);
        alu_vec("sltu", 4'd7,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,      32'd0);
        alu_vec("sll",  4'd8,  32'd0,          32'd3,          5'd4,  32'd0,      32'h30);
        alu_vec("srl",  4'd9,  32'd0,          32'h8000_0000,  5'd31, 32'd0,      32'd1);
        alu_vec("sra",  4'd10, 32'd0,          32'h8000_0000,  5'd4,  32'd0,      32'hF800_0000);
        alu_vec("lui",  4'd11, 32'd0,          32'd0,          5'd0,  32'h1234,   32'h1234_0000);
        alu_vec("zero", 4'd15, 32'hAAAA,       32'h5555,       5'd0,  32'd0,      32'd0);

        clear_inputs();
        ex_rs = 5'd3; ex_rt = 5'd4; ex_rs1_val = 32'h99; ex_rs2_val = 32'h77;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_fwd_val = 32'h10;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_fwd_val = 32'h20;
        ex_imm = 32'd4; ex_alu_src = 1'b1;
        #1;
        chk("fwd_mem_prio", alu_result, 32'h14);
        chk("fwd_store_none", store_val, 32'h77);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", alu_result, 32'h24);
        mem_reg_write = 1'b1; ex_rs = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        chk("fwd_r0", alu_result, 32'h9D);
        wb_rd = 5'd4;
        #1;
        chk("fwd_store_wb", store_val, 32'h20);

        clear_inputs();
        ex_rt = 5'd9; ex_rd = 5'd17; ex_pc_plus4 = 32'h400; ex_rs1_val = 32'd1;
        #1;
        chk("dest_rt", {27'd0, dest_reg}, 32'd9);
        ex_reg_dst = 1'b1;
        #1;
        chk("dest_rd", {27'd0, dest_reg}, 32'd17);
        ex_jal = 1'b1;
        #1;
        chk("jal_dest", {27'd0, dest_reg}, 32'd31);
        chk("jal_result", alu_result, 32'h400);

        clear_inputs();
        ex_is_branch_ne = 1'b1; ex_rs1_val = 32'd1; ex_rs2_val = 32'd2;
        ex_pc_plus4 = 32'h100; ex_imm = 32'hFFFF_FFFF;
        #1;
        chk("bne_taken", {31'd0, branch_taken}, 32'd1);
        chk("br_target", branch_target, 32'hFC);
        ex_rs2_val = 32'd1;
        #1;
        chk("bne_not_taken", {31'd0, branch_taken}, 32'd0);
        ex_is_branch_ne = 1'b0; ex_is_branch = 1'b1;
        #1;
        chk("beq_taken", {31'd0, branch_taken}, 32'd1);
        ex_rs2_val = 32'd3; ex_imm = 32'd8;
        #1;
        chk("beq_not_taken", {31'd0, branch_taken}, 32'd0);
        chk("br_target_fwd", branch_target, 32'h120);

`ifdef EX_MULDIV_EN
        clear_inputs();
        cycle();
        ex_alu_ctrl = 4'd12; ex_rs1_val = 32'h10000; ex_rs2_val = 32'h10001;
        #1;
        count_busy(n);
        chk("mul_busy_cycles", n, 32'd33);
        chk("mul_result", alu_result, 32'h0001_0000);
        ex_alu_ctrl = 4'd0; ex_rs1_val = 32'd5; ex_rs2_val = 32'd7;
        cycle();
        chk("after_mul_busy", {31'd0, ex_busy}, 32'd0);
        chk("after_mul_add", alu_result, 32'd12);

        ex_alu_ctrl = 4'd13; ex_rs1_val = 32'd100; ex_rs2_val = 32'd0;
        #1;
        count_busy(n);
        chk("divz_busy_cycles", n, 32'd33);
        chk("divz_quot", alu_result, 32'hFFFF_FFFF);
        ex_alu_ctrl = 4'd14;
        cycle();
        chk("b2b_start_busy", {31'd0, ex_busy}, 32'd1);
        count_busy(n);
        chk("remz_busy_cycles", n, 32'd33);
        chk("remz_rem", alu_result, 32'd100);

        ex_alu_ctrl = 4'd13; ex_rs2_val = 32'd7;
        cycle();
        count_busy(n);
        chk("divu_quot", alu_result, 32'd14);
        ex_alu_ctrl = 4'd14;
        cycle();
        count_busy(n);
        chk("remu_rem", alu_result, 32'd2);
        ex_alu_ctrl = 4'd0;
        cycle();

        ex_alu_ctrl = 4'd12; ex_rs1_val = 32'd3; ex_rs2_val = 32'd4;
        repeat (10) cycle();
        ex_kill = 1'b1;
        #1;
        chk("kill_busy_same", {31'd0, ex_busy}, 32'd0);
        cycle();
        ex_kill = 1'b0; ex_alu_ctrl = 4'd0; ex_rs1_val = 32'd5; ex_rs2_val = 32'd7;
        #1;
        chk("kill_next_busy", {31'd0, ex_busy}, 32'd0);
        chk("kill_next_add", alu_result, 32'd12);

        ex_alu_ctrl = 4'd13; ex_rs1_val = 32'd100; ex_rs2_val = 32'd7;
        cycle();
        repeat (10) cycle();
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, ex_busy}, 32'd0);
        chk("rst_mid_result", alu_result, 32'd0);
        cycle();
        reset = 1'b0; ex_alu_ctrl = 4'd0;
        #1;
        chk("rst_next_busy", {31'd0, ex_busy}, 32'd0);
        chk("rst_next_add", alu_result, 32'd107);
`else
        clear_inputs();
        alu_vec("mul_off",  4'd12, 32'd3,   32'd4, 5'd0, 32'd0, 32'd0);
        alu_vec("divu_off", 4'd13, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0);
        alu_vec("remu_off", 4'd14, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0);
        ex_alu_ctrl = 4'd12;
        cycle();
        chk("mul_off_busy_later", {31'd0, ex_busy}, 32'd0);
        ex_kill = 1'b1; ex_alu_ctrl = 4'd0; ex_rs1_val = 32'd5; ex_rs2_val = 32'd7;
        #1;
        chk("kill_add", alu_result, 32'd12);
        chk("kill_busy", {31'd0, ex_busy}, 32'd0);
        ex_kill = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
